// File: rtl/banked_mem_model_pkg.sv
// -----------------------------------------------------------------------------
// banked_mem_model_pkg
// Shared constants and address-split helpers for the banked memory model.
//   RD_LATENCY_MAX : largest supported read latency
//   CNT_W          : width of the write/read conflict counter
//   bank_index()   : bank number taken from the low address bits
//   word_index()   : word number taken from the bits above the bank field
// -----------------------------------------------------------------------------
package banked_mem_model_pkg;

    localparam int RD_LATENCY_MAX = 4;
    localparam int CNT_W          = 16;

    // Low bank_w bits pick the bank; a single-bank memory always uses bank 0.
    function automatic int unsigned bank_index(input logic [31:0] addr,
                                               input int unsigned bank_w);
        if (bank_w == 0) begin
            return 0;
        end
        return int'(addr & ((32'd1 << bank_w) - 32'd1));
    endfunction

    // Everything above the bank field is the word index inside that bank.
    function automatic int unsigned word_index(input logic [31:0] addr,
                                               input int unsigned bank_w);
        return int'(addr >> bank_w);
    endfunction

endpackage

// File: rtl/banked_mem_model_if.sv
// -----------------------------------------------------------------------------
// banked_mem_model_if
// Write/read request bus of the banked memory model.
//   wr_req/wr_addr/wr_data -> wr_gnt : write request held until granted
//   rd_req/rd_addr         -> rd_gnt : read request held until granted
//   rd_valid/rd_data                 : one strobe per granted read, in order
// master modport drives requests, slave modport (the memory) answers.
// -----------------------------------------------------------------------------
interface banked_mem_model_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_gnt;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_gnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_gnt, rd_gnt, rd_data, rd_valid
    );

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_gnt, rd_gnt, rd_data, rd_valid
    );
endinterface

// File: rtl/banked_mem_model_bank.sv
// -----------------------------------------------------------------------------
// mem_bank
// One single-port DEPTH x DATA_W bank with a registered read output.
//   clk   : clock
//   en    : access this cycle (read or write)
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word index inside the bank
//   wdata : write data
//   rdata : read data, updated only by a read access
// -----------------------------------------------------------------------------
module mem_bank #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [WORD_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array and its read register carry no reset so the bank maps
    // onto plain RAM; consumers qualify rdata with their own valid bits.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/banked_mem_model.sv
// -----------------------------------------------------------------------------
// banked_mem_model
// NUM_BANKS single-port banks behind one write port and one read port.
// A read and a write to different enabled banks proceed together; on a
// same-bank collision the read wins and the write stalls. Requests to a
// disabled bank (or past DEPTH) are refused and latch access_err.
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   bank_en      : per-bank enable, 0 = bank powered down
//   bus          : request bus (slave side), see banked_mem_model_if
//   access_err   : sticky, set by any request to an unusable bank
//   conflict_cnt : saturating count of write-stall cycles
// -----------------------------------------------------------------------------
module banked_mem_model
    import banked_mem_model_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 256,
    parameter int NUM_BANKS  = 4,
    parameter int RD_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_BANKS-1:0] bank_en,
    banked_mem_model_if.slave    bus,
    output logic                 access_err,
    output logic [CNT_W-1:0]     conflict_cnt
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
    localparam int ADDR_W = $clog2(DEPTH) + BANK_W;
    localparam int WORD_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SEL_W  = (BANK_W > 0) ? BANK_W : 1;

    logic [SEL_W-1:0]  wr_sel, rd_sel, bsel_q;
    logic [WORD_W-1:0] wr_word, rd_word;
    logic              wr_ok, rd_ok, same_bank;
    logic              wr_gnt_c, rd_gnt_c, wr_stall, err_hit;

    logic [NUM_BANKS-1:0] bank_rd, bank_wr;
    logic [DATA_W-1:0]    bank_q [NUM_BANKS];

    logic [RD_LATENCY-1:0] vld;
    logic [DATA_W-1:0]     stage1_data, data_out, hold_q;

    // ---------------------------------------------------------------- arbitration
    always_comb begin
        // NOTE: every output of this block gets a value on every path, so no
        // latch can be inferred.
        wr_sel  = SEL_W'(bank_index(32'(bus.wr_addr), BANK_W));
        rd_sel  = SEL_W'(bank_index(32'(bus.rd_addr), BANK_W));
        wr_word = WORD_W'(word_index(32'(bus.wr_addr), BANK_W));
        rd_word = WORD_W'(word_index(32'(bus.rd_addr), BANK_W));

        // An out-of-range word is handled exactly like a powered-down bank.
        wr_ok = (word_index(32'(bus.wr_addr), BANK_W) < DEPTH) && bank_en[wr_sel];
        rd_ok = (word_index(32'(bus.rd_addr), BANK_W) < DEPTH) && bank_en[rd_sel];

        same_bank = (wr_sel == rd_sel);
        rd_gnt_c  = rst_n && bus.rd_req && rd_ok;
        wr_stall  = bus.wr_req && wr_ok && rd_gnt_c && same_bank;
        wr_gnt_c  = rst_n && bus.wr_req && wr_ok && !wr_stall;
        err_hit   = (bus.wr_req && !wr_ok) || (bus.rd_req && !rd_ok);
    end

    assign bus.wr_gnt = wr_gnt_c;
    assign bus.rd_gnt = rd_gnt_c;

    // ---------------------------------------------------------------- banks
    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign bank_rd[b] = rd_gnt_c && (rd_sel == SEL_W'(b));
        assign bank_wr[b] = wr_gnt_c && (wr_sel == SEL_W'(b));

        mem_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .WORD_W (WORD_W)
        ) u_bank (
            .clk   (clk),
            .en    (bank_rd[b] | bank_wr[b]),
            .we    (bank_wr[b]),
            .addr  (bank_rd[b] ? rd_word : wr_word),
            .wdata (bus.wr_data),
            .rdata (bank_q[b])
        );
    end

    // ---------------------------------------------------------------- read return
    // vld[0] marks the cycle right after a grant, when the bank register holds
    // the word; bsel_q remembers which bank that was.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            vld <= '0;
        end else begin
            vld <= RD_LATENCY'({vld, rd_gnt_c});
        end
    end

    always_ff @(posedge clk) begin
        if (rd_gnt_c) begin
            bsel_q <= rd_sel;
        end
    end

    assign stage1_data = bank_q[bsel_q];

    if (RD_LATENCY == 1) begin : g_lat1
        assign data_out = stage1_data;
    end else begin : g_latn
        localparam int DP_W = (RD_LATENCY - 1) * DATA_W;
        logic [RD_LATENCY-2:0][DATA_W-1:0] dpipe;

        // Data rides alongside vld; entry 0 is the youngest.
        always_ff @(posedge clk) begin
            dpipe <= DP_W'({dpipe, stage1_data});
        end

        assign data_out = dpipe[RD_LATENCY-2];
    end

    assign bus.rd_valid = vld[RD_LATENCY-1];
    // Between strobes the last delivered word is replayed from hold_q.
    assign bus.rd_data  = vld[RD_LATENCY-1] ? data_out : hold_q;

    // ---------------------------------------------------------------- status
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            access_err   <= 1'b0;
            conflict_cnt <= '0;
            hold_q       <= '0;
        end else begin
            if (err_hit) begin
                access_err <= 1'b1;
            end
            if (wr_stall && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
            hold_q <= bus.rd_data;
        end
    end

    // ---------------------------------------------------------------- checks
    always_ff @(posedge clk) begin
        assert (RD_LATENCY >= 1 && RD_LATENCY <= RD_LATENCY_MAX);
        assert ($bits(bus.wr_addr) == ADDR_W);
        assert (rst_n || !(wr_gnt_c || rd_gnt_c));
        assert ((bank_rd & bank_wr) == '0);
    end

endmodule
